// File: rtl/frame_mem_arbiter.sv
// Frame SRAM arbiter: one ZBT SRAM shared by VGA display reads, NTSC capture writes
// and processor accesses, with double-buffered video frames swapped at VGA frame start.
module frame_mem_arbiter #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 36,
    parameter int FRAME_WORDS = 131072,
    parameter int RD_LAT      = 2,
    parameter int STARVE_MAX  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_flag,
    input  logic              vga_flag,
    output logic              done_vga,
    output logic [DATA_W-1:0] vga_pixel,
    input  logic              ntsc_flag,
    input  logic [DATA_W-1:0] ntsc_pixel,
    input  logic              ntsc_frame_done,
    output logic              done_ntsc,
    input  logic              proc_req,
    input  logic              proc_we,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [DATA_W-1:0] proc_wdata,
    output logic [DATA_W-1:0] proc_rdata,
    output logic              done_proc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              display_buf,
    output logic [2:0]        req_overflow
);
    localparam int CNT_W = $clog2(FRAME_WORDS);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] BUF_BASE = ADDR_W'(FRAME_WORDS);

    typedef enum logic [1:0] {GNT_NONE, GNT_VGA, GNT_NTSC, GNT_PROC} grant_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_PROC} tag_t;

    // Request handshake: each port raises a one-cycle pulse. The pulse sets the
    // port's pending bit unless that bit is already set on the same edge (even
    // if it is being granted there), in which case the new request is dropped
    // and the sticky overflow bit is raised. A grant clears the pending bit.
    logic              r_pend_vga, r_pend_ntsc, r_pend_proc;
    logic [DATA_W-1:0] r_ntsc_data;
    logic              r_proc_we;
    logic [ADDR_W-1:0] r_proc_addr;
    logic [DATA_W-1:0] r_proc_wdata;
    logic [2:0]        r_overflow;

    logic [CNT_W-1:0]  r_vga_cnt, r_ntsc_cnt;
    logic [SC_W-1:0]   r_starve;
    logic              r_frame_ready, r_display_buf;

    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    tag_t              r_tag [RD_LAT+1];
    logic              r_done_vga, r_done_ntsc, r_done_proc;
    logic [DATA_W-1:0] r_vga_pixel, r_proc_rdata;

    grant_t            w_grant;
    tag_t              w_issue_tag;
    logic [ADDR_W-1:0] w_vga_addr, w_ntsc_addr;

    assign w_vga_addr  = (r_display_buf ? BUF_BASE : '0) + ADDR_W'(r_vga_cnt);
    assign w_ntsc_addr = (r_display_buf ? '0 : BUF_BASE) + ADDR_W'(r_ntsc_cnt);

    // A starved processor pre-empts the fixed VGA > NTSC > PROC order.
    always_comb begin
        w_grant     = GNT_NONE;
        w_issue_tag = TAG_NONE;
        if (r_pend_proc && (r_starve == SC_W'(STARVE_MAX))) begin
            w_grant = GNT_PROC;
        end else if (r_pend_vga) begin
            w_grant = GNT_VGA;
        end else if (r_pend_ntsc) begin
            w_grant = GNT_NTSC;
        end else if (r_pend_proc) begin
            w_grant = GNT_PROC;
        end
        if (w_grant == GNT_VGA) begin
            w_issue_tag = TAG_VGA;
        end else if ((w_grant == GNT_PROC) && !r_proc_we) begin
            w_issue_tag = TAG_PROC;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pend_vga   <= 1'b0;
            r_pend_ntsc  <= 1'b0;
            r_pend_proc  <= 1'b0;
            r_ntsc_data  <= '0;
            r_proc_we    <= 1'b0;
            r_proc_addr  <= '0;
            r_proc_wdata <= '0;
            r_overflow   <= '0;
        end else begin
            if (w_grant == GNT_VGA)  r_pend_vga  <= 1'b0;
            if (w_grant == GNT_NTSC) r_pend_ntsc <= 1'b0;
            if (w_grant == GNT_PROC) r_pend_proc <= 1'b0;

            if (vga_flag) begin
                if (r_pend_vga) r_overflow[0] <= 1'b1;
                else            r_pend_vga    <= 1'b1;
            end
            if (ntsc_flag) begin
                if (r_pend_ntsc) begin
                    r_overflow[1] <= 1'b1;
                end else begin
                    r_pend_ntsc <= 1'b1;
                    r_ntsc_data <= ntsc_pixel;
                end
            end
            if (proc_req) begin
                if (r_pend_proc) begin
                    r_overflow[2] <= 1'b1;
                end else begin
                    r_pend_proc  <= 1'b1;
                    r_proc_we    <= proc_we;
                    r_proc_addr  <= proc_addr;
                    r_proc_wdata <= proc_wdata;
                end
            end
        end
    end

    // Counter resets and the buffer swap take effect after this edge, so a grant
    // on the same edge still uses the old count and buffer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vga_cnt     <= '0;
            r_ntsc_cnt    <= '0;
            r_starve      <= '0;
            r_frame_ready <= 1'b0;
            r_display_buf <= 1'b0;
        end else begin
            if (frame_flag)                r_vga_cnt <= '0;
            else if (w_grant == GNT_VGA)   r_vga_cnt <= r_vga_cnt + 1'b1;

            if (ntsc_frame_done)           r_ntsc_cnt <= '0;
            else if (w_grant == GNT_NTSC)  r_ntsc_cnt <= r_ntsc_cnt + 1'b1;

            if (w_grant == GNT_PROC)       r_starve <= '0;
            else if (r_pend_proc)          r_starve <= r_starve + 1'b1;

            if (frame_flag && r_frame_ready) r_display_buf <= ~r_display_buf;
            if (ntsc_frame_done)             r_frame_ready <= 1'b1;
            else if (frame_flag)             r_frame_ready <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_done_ntsc  <= 1'b0;
            r_done_vga   <= 1'b0;
            r_done_proc  <= 1'b0;
            r_vga_pixel  <= '0;
            r_proc_rdata <= '0;
            for (int i = 0; i <= RD_LAT; i++) r_tag[i] <= TAG_NONE;
        end else begin
            r_mem_we <= 1'b0;
            case (w_grant)
                GNT_VGA: r_mem_addr <= w_vga_addr;
                GNT_NTSC: begin
                    r_mem_addr  <= w_ntsc_addr;
                    r_mem_we    <= 1'b1;
                    r_mem_wdata <= r_ntsc_data;
                end
                GNT_PROC: begin
                    r_mem_addr <= r_proc_addr;
                    r_mem_we   <= r_proc_we;
                    if (r_proc_we) r_mem_wdata <= r_proc_wdata;
                end
                default: ;
            endcase

            // The tag leaving the last stage marks the cycle its read data is on mem_rdata.
            r_tag[0] <= w_issue_tag;
            for (int i = 1; i <= RD_LAT; i++) r_tag[i] <= r_tag[i-1];

            r_done_ntsc <= (w_grant == GNT_NTSC);
            r_done_vga  <= (r_tag[RD_LAT] == TAG_VGA);
            r_done_proc <= (r_tag[RD_LAT] == TAG_PROC) ||
                           ((w_grant == GNT_PROC) && r_proc_we);
            if (r_tag[RD_LAT] == TAG_VGA)  r_vga_pixel  <= mem_rdata;
            if (r_tag[RD_LAT] == TAG_PROC) r_proc_rdata <= mem_rdata;
        end
    end

    assign mem_addr     = r_mem_addr;
    assign mem_we       = r_mem_we;
    assign mem_wdata    = r_mem_wdata;
    assign done_vga     = r_done_vga;
    assign vga_pixel    = r_vga_pixel;
    assign done_ntsc    = r_done_ntsc;
    assign done_proc    = r_done_proc;
    assign proc_rdata   = r_proc_rdata;
    assign display_buf  = r_display_buf;
    assign req_overflow = r_overflow;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter with a pipelined SRAM model whose read data
// equals the address sampled RD_LAT clocks earlier.
module tb_frame_mem_arbiter;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 36;

    logic              clock;
    logic              reset;
    logic              frame_flag, vga_flag, ntsc_flag, ntsc_frame_done;
    logic              proc_req, proc_we;
    logic [ADDR_W-1:0] proc_addr;
    logic [DATA_W-1:0] ntsc_pixel, proc_wdata;
    logic              done_vga, done_ntsc, done_proc, mem_we, display_buf;
    logic [DATA_W-1:0] vga_pixel, proc_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        req_overflow;

    logic [ADDR_W-1:0] r_a1, r_a2;
    logic [DATA_W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    frame_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_WORDS(16), .RD_LAT(2), .STARVE_MAX(8)
    ) dut (
        .clock(clock), .reset(reset),
        .frame_flag(frame_flag), .vga_flag(vga_flag),
        .done_vga(done_vga), .vga_pixel(vga_pixel),
        .ntsc_flag(ntsc_flag), .ntsc_pixel(ntsc_pixel),
        .ntsc_frame_done(ntsc_frame_done), .done_ntsc(done_ntsc),
        .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr),
        .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .done_proc(done_proc),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .display_buf(display_buf), .req_overflow(req_overflow)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ZBT model: address sampled one edge after issue, data valid two edges later.
    always @(posedge clock) begin
        r_a1 <= mem_addr;
        r_a2 <= r_a1;
    end
    assign mem_rdata = DATA_W'(r_a2);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        frame_flag = 0; vga_flag = 0; ntsc_flag = 0; ntsc_frame_done = 0;
        proc_req = 0; proc_we = 0; proc_addr = '0; ntsc_pixel = '0; proc_wdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    function automatic logic outputs_all_zero();
        return ({done_vga, vga_pixel, done_ntsc, proc_rdata, done_proc, mem_addr,
                 mem_we, mem_wdata, display_buf, req_overflow} === '0);
    endfunction

    task automatic test_reset();
        int lat;
        do_reset();
        n_tests++;
        if (!outputs_all_zero()) begin
            n_fail++;
            $display("FAIL reset_outputs: mem_addr=%h mem_we=%b done=%b%b%b buf=%b ovf=%b, required all 0",
                     mem_addr, mem_we, done_vga, done_ntsc, done_proc, display_buf, req_overflow);
        end
        vga_flag = 1; tick(); vga_flag = 0;
        n_tests++;
        if (done_vga !== 1'b0) begin n_fail++; $display("FAIL early_done_vga: got %b required 0", done_vga); end
        tick();
        n_tests++;
        if (mem_addr !== 19'h0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL vga_grant: mem_addr=%h mem_we=%b required 0/0", mem_addr, mem_we);
        end
        lat = 0;
        while (done_vga !== 1'b1 && lat < 10) begin tick(); lat++; end
        n_tests++;
        if (lat != 3) begin n_fail++; $display("FAIL vga_latency: done_vga %0d cycles after grant, required 3", lat); end
        n_tests++;
        if (vga_pixel !== 36'h0) begin n_fail++; $display("FAIL vga_pixel0: got %h required 0", vga_pixel); end
        tick();
        n_tests++;
        if (done_vga !== 1'b0) begin n_fail++; $display("FAIL done_vga_pulse: got %b required 0", done_vga); end
    endtask

    task automatic test_priority();
        do_reset();
        vga_flag = 1; ntsc_flag = 1; ntsc_pixel = 36'hABC;
        proc_req = 1; proc_we = 0; proc_addr = 19'h100;
        tick(); clear_inputs();
        tick();
        n_tests++;
        if (mem_addr !== 19'd0 || mem_we !== 1'b0 || done_ntsc !== 1'b0) begin
            n_fail++; $display("FAIL prio_vga: addr=%h we=%b done_ntsc=%b required 0/0/0", mem_addr, mem_we, done_ntsc);
        end
        tick();
        n_tests++;
        if (mem_addr !== 19'd16 || mem_we !== 1'b1 || mem_wdata !== 36'hABC || done_ntsc !== 1'b1) begin
            n_fail++; $display("FAIL prio_ntsc: addr=%h we=%b wdata=%h done_ntsc=%b required 10/1/abc/1",
                               mem_addr, mem_we, mem_wdata, done_ntsc);
        end
        tick();
        n_tests++;
        if (mem_addr !== 19'h100 || mem_we !== 1'b0 || done_ntsc !== 1'b0) begin
            n_fail++; $display("FAIL prio_proc: addr=%h we=%b done_ntsc=%b required 100/0/0", mem_addr, mem_we, done_ntsc);
        end
        tick();
        n_tests++;
        if (done_vga !== 1'b1 || vga_pixel !== 36'h0) begin
            n_fail++; $display("FAIL prio_vga_data: done=%b pixel=%h required 1/0", done_vga, vga_pixel);
        end
        tick();
        n_tests++;
        if (done_proc !== 1'b0) begin n_fail++; $display("FAIL prio_proc_early: done_proc=%b required 0", done_proc); end
        tick();
        n_tests++;
        if (done_proc !== 1'b1 || proc_rdata !== 36'h100) begin
            n_fail++; $display("FAIL prio_proc_data: done=%b rdata=%h required 1/100", done_proc, proc_rdata);
        end
        proc_req = 1; proc_we = 1; proc_addr = 19'h55; proc_wdata = 36'h123;
        tick(); clear_inputs();
        tick();
        n_tests++;
        if (mem_addr !== 19'h55 || mem_we !== 1'b1 || mem_wdata !== 36'h123 || done_proc !== 1'b1) begin
            n_fail++; $display("FAIL proc_write: addr=%h we=%b wdata=%h done=%b required 55/1/123/1",
                               mem_addr, mem_we, mem_wdata, done_proc);
        end
        tick();
        n_tests++;
        if (mem_addr !== 19'h55 || mem_we !== 1'b0 || done_proc !== 1'b0) begin
            n_fail++; $display("FAIL idle_hold: addr=%h we=%b done=%b required 55/0/0", mem_addr, mem_we, done_proc);
        end
    endtask

    task automatic test_starvation();
        logic              exp_proc;
        logic [ADDR_W-1:0] exp_a;
        do_reset();
        for (int i = 0; i <= 30; i++) begin
            vga_flag  = 1;
            ntsc_flag = 1;
            proc_req  = (i == 0 || i == 21);
            proc_we   = 0;
            proc_addr = (i == 21) ? 19'h1E0 : 19'h1F0;
            tick();
            if (i >= 1) begin
                exp_proc = (i == 9) || (i == 30);
                exp_a    = (i == 30) ? 19'h1E0 : 19'h1F0;
                n_tests++;
                if (exp_proc && (mem_addr !== exp_a || mem_we !== 1'b0)) begin
                    n_fail++; $display("FAIL starve_grant edge %0d: addr=%h we=%b required %h/0", i, mem_addr, mem_we, exp_a);
                end else if (!exp_proc && (mem_addr === 19'h1F0 || mem_addr === 19'h1E0)) begin
                    n_fail++; $display("FAIL starve_early edge %0d: addr=%h required a VGA/NTSC address", i, mem_addr);
                end
            end
            if (i == 12) begin
                n_tests++;
                if (done_proc !== 1'b1 || proc_rdata !== 36'h1F0) begin
                    n_fail++; $display("FAIL starve_rdata: done=%b rdata=%h required 1/1f0", done_proc, proc_rdata);
                end
            end
        end
        clear_inputs();
        tick();
        n_tests++;
        if (req_overflow !== 3'b011) begin
            n_fail++; $display("FAIL starve_overflow: got %b required 011", req_overflow);
        end
    endtask

    task automatic test_frame_swap();
        do_reset();
        for (int n = 0; n < 16; n++) begin
            ntsc_flag = 1; ntsc_pixel = DATA_W'(36'h100 + n);
            tick();
            ntsc_flag = 0;
            tick();
            n_tests++;
            if (mem_addr !== ADDR_W'(16 + n) || mem_we !== 1'b1 || mem_wdata !== DATA_W'(36'h100 + n) || done_ntsc !== 1'b1) begin
                n_fail++; $display("FAIL ntsc_write %0d: addr=%h we=%b wdata=%h done=%b required %h/1/%h/1",
                                   n, mem_addr, mem_we, mem_wdata, done_ntsc, 16 + n, 36'h100 + n);
            end
        end
        ntsc_frame_done = 1; tick(); ntsc_frame_done = 0;
        n_tests++;
        if (display_buf !== 1'b0) begin n_fail++; $display("FAIL swap_early: display_buf=%b required 0", display_buf); end
        frame_flag = 1; tick(); frame_flag = 0;
        n_tests++;
        if (display_buf !== 1'b1) begin n_fail++; $display("FAIL swap: display_buf=%b required 1", display_buf); end
        vga_flag = 1; tick(); vga_flag = 0; tick();
        n_tests++;
        if (mem_addr !== 19'd16) begin n_fail++; $display("FAIL swap_vga_addr: got %h required 10", mem_addr); end
        ntsc_flag = 1; ntsc_pixel = 36'h7; tick(); ntsc_flag = 0; tick();
        n_tests++;
        if (mem_addr !== 19'd0 || mem_we !== 1'b1) begin
            n_fail++; $display("FAIL swap_ntsc_addr: addr=%h we=%b required 0/1", mem_addr, mem_we);
        end
        frame_flag = 1; tick(); frame_flag = 0;
        n_tests++;
        if (display_buf !== 1'b1) begin n_fail++; $display("FAIL no_toggle: display_buf=%b required 1", display_buf); end
        frame_flag = 1; ntsc_frame_done = 1; tick(); frame_flag = 0; ntsc_frame_done = 0;
        n_tests++;
        if (display_buf !== 1'b1) begin n_fail++; $display("FAIL same_edge_swap: display_buf=%b required 1", display_buf); end
        frame_flag = 1; tick(); frame_flag = 0;
        n_tests++;
        if (display_buf !== 1'b0) begin n_fail++; $display("FAIL deferred_swap: display_buf=%b required 0", display_buf); end
        vga_flag = 1; tick(); vga_flag = 0; tick();
        n_tests++;
        if (mem_addr !== 19'd0) begin n_fail++; $display("FAIL swap_back_vga: got %h required 0", mem_addr); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp;
        int n_done;
        do_reset();
        exp_q.delete();
        n_done = 0;
        for (int i = 0; i <= 40; i++) begin
            vga_flag = (i % 2 == 0) && (i < 34);
            tick();
            if ((i % 2 == 1) && (i < 34)) begin
                n_tests++;
                if (mem_addr !== ADDR_W'(((i - 1) / 2) % 16)) begin
                    n_fail++; $display("FAIL vga_seq_addr edge %0d: got %h required %h", i, mem_addr, ((i - 1) / 2) % 16);
                end
                exp_q.push_back(DATA_W'(((i - 1) / 2) % 16));
            end
            if (done_vga === 1'b1) begin
                n_done++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL vga_seq_extra: pixel=%h with nothing expected", vga_pixel);
                end else begin
                    exp = exp_q.pop_front();
                    if (vga_pixel !== exp) begin
                        n_fail++; $display("FAIL vga_seq_data: got %h required %h", vga_pixel, exp);
                    end
                end
            end
        end
        n_tests++;
        if (n_done != 17 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL vga_seq_count: %0d returned required 17", n_done);
        end
        vga_flag = 1; tick();
        vga_flag = 1; tick();
        vga_flag = 0; tick();
        n_tests++;
        if (req_overflow !== 3'b001 || mem_addr !== 19'd1) begin
            n_fail++; $display("FAIL vga_overflow: ovf=%b addr=%h required 001/1", req_overflow, mem_addr);
        end
    endtask

    task automatic test_reset_in_flight();
        int n_done;
        do_reset();
        vga_flag = 1; proc_req = 1; proc_we = 1; proc_addr = 19'h55; proc_wdata = 36'h77;
        tick(); clear_inputs();
        tick();
        tick();
        n_tests++;
        if (mem_addr !== 19'h55 || mem_we !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_state: addr=%h we=%b required 55/1", mem_addr, mem_we);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (!outputs_all_zero()) begin
            n_fail++; $display("FAIL async_reset: addr=%h we=%b wdata=%h done_proc=%b required all 0",
                               mem_addr, mem_we, mem_wdata, done_proc);
        end
        tick();
        reset = 1'b1;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done_vga === 1'b1) n_done++;
        end
        n_tests++;
        if (n_done != 0 || !outputs_all_zero()) begin
            n_fail++; $display("FAIL discarded_read: %0d done_vga pulses, addr=%h, required none and all 0", n_done, mem_addr);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_priority();
        test_starvation();
        test_frame_swap();
        test_back_to_back();
        test_reset_in_flight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
